pc_sequencer: RTL and testbench

Fetch-side consumer of the 2-bit PC-select code from the EX-stage branch decision. Holds the architectural PC and runs a single-outstanding request/acknowledge fetch to instruction memory. Applies redirects (branch, JAL, JALR) with a pipeline flush and buffers one instruction under load-use stall. Drives the IF/ID register inputs.

---
 rtl/rv_pipe_pkg.sv | 20 ++
 rtl/pc_target_calc.sv | 28 ++
 rtl/pc_sequencer.sv | 154 +++++++++++++++
 tb/tb_pc_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared fetch/branch definitions: PC-select encodings, sequencer states, NOP.
package rv_pipe_pkg;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'b00,
      PC_BRANCH = 2'b01,
      PC_JAL    = 2'b10,
      PC_JALR   = 2'b11
   } pc_sel_e;

   typedef enum logic [1:0] {
      ST_BOOT    = 2'b00,
      ST_FETCH   = 2'b01,
      ST_HOLD    = 2'b10,
      ST_DISCARD = 2'b11
   } seq_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target computation: branch/JAL/JALR target, misalignment check
// and substitution of the trap vector.
module pc_target_calc
   import rv_pipe_pkg::*;
#(
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic [1:0]  i_pc_sel,
   input  logic [31:0] i_ex_pc,
   input  logic [31:0] i_ex_imm,
   input  logic [31:0] i_jalr_base,
   output logic [31:0] o_eff_target,
   output logic        o_misaligned
);

   logic [31:0] w_target;

   always_comb begin
      w_target = i_ex_pc + i_ex_imm;
      // JALR clears bit 0 before the alignment check, so only bit 1 can trap.
      if (i_pc_sel == PC_JALR) begin
         w_target = (i_jalr_base + i_ex_imm) & ~32'h1;
      end
      o_misaligned = (i_pc_sel != PC_PLUS4) && (w_target[1:0] != 2'b00);
      o_eff_target = o_misaligned ? TRAP_VEC : w_target;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: single-outstanding imem fetch, redirect/flush
// handling and a one-entry skid buffer for load-use stalls.
module pc_sequencer
   import rv_pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  pcSel,
   input  logic [31:0] exPc,
   input  logic [31:0] exImm,
   input  logic [31:0] jalrBase,
   input  logic        stall,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemAck,
   input  logic [31:0] imemRdata,
   output logic        ifValid,
   output logic [31:0] ifInstr,
   output logic [31:0] ifPc,
   output logic        flush,
   output logic        misalignTrap
);

   seq_state_e  r_state, w_nxt_state;
   logic [31:0] r_pc, w_nxt_pc;
   logic [31:0] r_disc_addr, w_nxt_disc_addr;
   logic        r_if_valid, w_nxt_if_valid;
   logic [31:0] r_if_instr, w_nxt_if_instr;
   logic [31:0] r_if_pc, w_nxt_if_pc;
   logic [31:0] r_skid_instr, w_nxt_skid_instr;
   logic [31:0] r_skid_pc, w_nxt_skid_pc;
   logic        r_flush, w_nxt_flush;
   logic        r_trap, w_nxt_trap;

   logic        w_redirect;
   logic [31:0] w_eff_target;
   logic        w_misaligned;

   pc_target_calc #(.TRAP_VEC(TRAP_VEC)) u_target (
      .i_pc_sel     (pcSel),
      .i_ex_pc      (exPc),
      .i_ex_imm     (exImm),
      .i_jalr_base  (jalrBase),
      .o_eff_target (w_eff_target),
      .o_misaligned (w_misaligned)
   );

   assign w_redirect = (pcSel != PC_PLUS4);

   always_comb begin
      // NOTE: every next-state value gets a default first so no latch is inferred.
      w_nxt_state      = r_state;
      w_nxt_pc         = r_pc;
      w_nxt_disc_addr  = r_disc_addr;
      w_nxt_if_valid   = r_if_valid;
      w_nxt_if_instr   = r_if_instr;
      w_nxt_if_pc      = r_if_pc;
      w_nxt_skid_instr = r_skid_instr;
      w_nxt_skid_pc    = r_skid_pc;
      w_nxt_flush      = 1'b0;
      w_nxt_trap       = 1'b0;

      if (r_state == ST_BOOT) begin
         w_nxt_state = ST_FETCH;
      end else if (w_redirect) begin
         w_nxt_flush      = 1'b1;
         w_nxt_trap       = w_misaligned;
         w_nxt_if_valid   = 1'b0;
         w_nxt_pc         = w_eff_target;
         w_nxt_skid_instr = NOP_INSTR;
         w_nxt_skid_pc    = 32'h0;
         if ((r_state == ST_HOLD) || imemAck) begin
            w_nxt_state = ST_FETCH;
         end else begin
            // The in-flight request keeps its original address until acked.
            w_nxt_state = ST_DISCARD;
            if (r_state == ST_FETCH) begin
               w_nxt_disc_addr = r_pc;
            end
         end
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (imemAck) begin
                  w_nxt_pc = r_pc + 32'd4;
                  if (stall) begin
                     w_nxt_skid_instr = imemRdata;
                     w_nxt_skid_pc    = r_pc;
                     w_nxt_state      = ST_HOLD;
                  end else begin
                     w_nxt_if_instr = imemRdata;
                     w_nxt_if_pc    = r_pc;
                     w_nxt_if_valid = 1'b1;
                  end
               end else if (!stall) begin
                  w_nxt_if_valid = 1'b0;
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  w_nxt_if_instr = r_skid_instr;
                  w_nxt_if_pc    = r_skid_pc;
                  w_nxt_if_valid = 1'b1;
                  w_nxt_state    = ST_FETCH;
               end
            end
            ST_DISCARD: begin
               if (imemAck) begin
                  w_nxt_state = ST_FETCH;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_BOOT;
         r_pc         <= RESET_PC;
         r_disc_addr  <= 32'h0;
         r_if_valid   <= 1'b0;
         r_if_instr   <= NOP_INSTR;
         r_if_pc      <= 32'h0;
         r_skid_instr <= NOP_INSTR;
         r_skid_pc    <= 32'h0;
         r_flush      <= 1'b0;
         r_trap       <= 1'b0;
      end else begin
         r_state      <= w_nxt_state;
         r_pc         <= w_nxt_pc;
         r_disc_addr  <= w_nxt_disc_addr;
         r_if_valid   <= w_nxt_if_valid;
         r_if_instr   <= w_nxt_if_instr;
         r_if_pc      <= w_nxt_if_pc;
         r_skid_instr <= w_nxt_skid_instr;
         r_skid_pc    <= w_nxt_skid_pc;
         r_flush      <= w_nxt_flush;
         r_trap       <= w_nxt_trap;
      end
   end

   assign imemReq      = (r_state == ST_FETCH) || (r_state == ST_DISCARD);
   assign imemAddr     = (r_state == ST_DISCARD) ? r_disc_addr : r_pc;
   assign ifValid      = r_if_valid;
   assign ifInstr      = r_if_instr;
   assign ifPc         = r_if_pc;
   assign flush        = r_flush;
   assign misalignTrap = r_trap;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: redirect vector table, hand-written
// stall/discard/reset sequences and a randomized run against a queue-based model.
module tb_pc_sequencer;
   import rv_pipe_pkg::*;

   localparam logic [31:0] TRAP = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  pcSel = 2'b00;
   logic [31:0] exPc = '0, exImm = '0, jalrBase = '0, imemRdata = '0;
   logic        stall = 1'b0, imemAck = 1'b0;
   logic        imemReq, ifValid, flush, misalignTrap;
   logic [31:0] imemAddr, ifInstr, ifPc;

   always #5 clk = ~clk;

   pc_sequencer #(.RESET_PC(32'h0), .TRAP_VEC(TRAP)) dut (
      .clk(clk), .rst_n(rst_n), .pcSel(pcSel), .exPc(exPc), .exImm(exImm),
      .jalrBase(jalrBase), .stall(stall), .imemReq(imemReq), .imemAddr(imemAddr),
      .imemAck(imemAck), .imemRdata(imemRdata), .ifValid(ifValid),
      .ifInstr(ifInstr), .ifPc(ifPc), .flush(flush), .misalignTrap(misalignTrap)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      pcSel = 2'b00; exPc = '0; exImm = '0; jalrBase = '0;
      stall = 1'b0; imemAck = 1'b0; imemRdata = '0;
   endtask

   task automatic hold_reset();
      rst_n = 1'b0;
      set_idle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Redirect vectors applied from FETCH with an ack in the same cycle.
   typedef struct {
      logic [1:0]  sel;
      logic [31:0] ex_pc, ex_imm, base, exp_addr;
      logic        exp_flush, exp_trap, exp_valid;
   } vec_t;
   vec_t vecs[8];

   // Behavioural model: fetching pauses while the skid queue holds data;
   // a squashed request is tracked by drop/drop_addr until its ack arrives.
   typedef struct { logic [31:0] instr, pc; } skid_t;
   skid_t       m_skid[$];
   logic        m_boot, m_drop, m_ifv, m_flush, m_trap;
   logic [31:0] m_pc, m_drop_addr, m_ifi, m_ifp;

   function automatic logic m_req();
      return !m_boot && (m_skid.size() == 0);
   endfunction

   task automatic model_reset();
      m_skid.delete();
      m_boot = 1'b1; m_drop = 1'b0; m_ifv = 1'b0; m_flush = 1'b0; m_trap = 1'b0;
      m_pc = 32'h0; m_drop_addr = 32'h0; m_ifi = NOP_INSTR; m_ifp = 32'h0;
   endtask

   task automatic model_step();
      logic [31:0] t;
      logic        mis;
      skid_t       s;
      if (m_boot) begin
         m_boot = 1'b0; m_flush = 1'b0; m_trap = 1'b0;
         return;
      end
      if (pcSel == 2'b11) t = (jalrBase + exImm) & 32'hFFFF_FFFE;
      else                t = exPc + exImm;
      mis = (t[1:0] != 2'b00);
      m_flush = 1'b0; m_trap = 1'b0;
      if (pcSel != 2'b00) begin
         m_flush = 1'b1; m_trap = mis; m_ifv = 1'b0;
         if (m_req() && !imemAck) begin
            if (!m_drop) m_drop_addr = m_pc;
            m_drop = 1'b1;
         end else begin
            m_drop = 1'b0;
         end
         m_pc = mis ? TRAP : t;
         m_skid.delete();
      end else if (m_skid.size() != 0) begin
         if (!stall) begin
            s = m_skid.pop_front();
            m_ifi = s.instr; m_ifp = s.pc; m_ifv = 1'b1;
         end
      end else if (m_drop) begin
         if (imemAck) m_drop = 1'b0;
      end else if (imemAck) begin
         if (stall) m_skid.push_back('{imemRdata, m_pc});
         else begin m_ifi = imemRdata; m_ifp = m_pc; m_ifv = 1'b1; end
         m_pc = m_pc + 32'd4;
      end else if (!stall) begin
         m_ifv = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{2'b01, 32'h0000_0040, 32'h0000_0020, 32'h0,         32'h0000_0060, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{2'b10, 32'h0000_1000, 32'hFFFF_FFF0, 32'h0,         32'h0000_0FF0, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{2'b11, 32'h0,         32'h0000_0002, 32'h0000_0101, TRAP,          1'b1, 1'b1, 1'b0};
      vecs[3] = '{2'b11, 32'h0,         32'h0,         32'h0000_0201, 32'h0000_0200, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{2'b01, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0,         32'h0000_0004, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{2'b10, 32'h0000_0010, 32'h0000_0006, 32'h0,         TRAP,          1'b1, 1'b1, 1'b0};
      vecs[6] = '{2'b11, 32'h0,         32'h0,         32'h0000_0003, TRAP,          1'b1, 1'b1, 1'b0};
      vecs[7] = '{2'b00, 32'h0000_0500, 32'h0000_0010, 32'h0,         32'h0000_0004, 1'b0, 1'b0, 1'b1};

      // Reset state.
      hold_reset();
      check("rst_req", 32'(imemReq), 32'h0);
      check("rst_valid", 32'(ifValid), 32'h0);
      check("rst_instr", ifInstr, NOP_INSTR);
      check("rst_pc", ifPc, 32'h0);
      check("rst_flush", 32'(flush), 32'h0);
      check("rst_trap", 32'(misalignTrap), 32'h0);
      release_reset();
      tick();

      // Sequential fetch, ack one cycle after each request, rdata = address.
      for (int k = 0; k < 4; k++) begin
         check("seq_req", 32'(imemReq), 32'h1);
         check("seq_addr", imemAddr, 32'(4 * k));
         tick();
         imemAck = 1'b1; imemRdata = 32'(4 * k);
         tick();
         imemAck = 1'b0;
         check("seq_instr", ifInstr, 32'(4 * k));
         check("seq_ifpc", ifPc, 32'(4 * k));
         check("seq_valid", 32'(ifValid), 32'h1);
         check("seq_flush", 32'(flush), 32'h0);
      end

      // Redirect with a request outstanding; its late data must be dropped.
      tick();
      pcSel = 2'b01; exPc = 32'h80; exImm = 32'h10;
      tick();
      set_idle();
      check("disc_flush", 32'(flush), 32'h1);
      check("disc_valid", 32'(ifValid), 32'h0);
      check("disc_addr_hold", imemAddr, 32'h10);
      tick();
      check("disc_flush_once", 32'(flush), 32'h0);
      imemAck = 1'b1; imemRdata = 32'hDEAD_BEEF;
      tick();
      imemAck = 1'b0;
      check("disc_dropped", ifInstr, 32'h0000_000C);
      check("disc_valid2", 32'(ifValid), 32'h0);
      check("disc_new_addr", imemAddr, 32'h90);
      check("disc_new_req", 32'(imemReq), 32'h1);
      imemAck = 1'b1; imemRdata = 32'h0000_1234;
      tick();
      imemAck = 1'b0;
      check("disc_after_instr", ifInstr, 32'h0000_1234);
      check("disc_after_pc", ifPc, 32'h90);

      // Stall at ack: data parks in the skid for three cycles.
      tick();
      imemAck = 1'b1; imemRdata = 32'h11; stall = 1'b1;
      tick();
      imemAck = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("stall_req", 32'(imemReq), 32'h0);
         check("stall_instr", ifInstr, 32'h0000_1234);
         check("stall_valid", 32'(ifValid), 32'h0);
         if (k < 2) tick();
      end
      stall = 1'b0;
      tick();
      check("unstall_instr", ifInstr, 32'h11);
      check("unstall_pc", ifPc, 32'h94);
      check("unstall_valid", 32'(ifValid), 32'h1);
      check("unstall_addr", imemAddr, 32'h98);

      // Reset mid-request, late ack and redirect during BOOT both ignored.
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("midrst_req", 32'(imemReq), 32'h0);
      @(negedge clk);
      pcSel = 2'b10; exPc = 32'h500; exImm = 32'h0; imemAck = 1'b1; imemRdata = 32'hBAD0_0000;
      rst_n = 1'b1;
      tick();
      set_idle();
      check("boot_flush", 32'(flush), 32'h0);
      check("boot_req", 32'(imemReq), 32'h1);
      check("boot_addr", imemAddr, 32'h0);
      check("boot_valid", 32'(ifValid), 32'h0);

      // Redirect vector table.
      for (int i = 0; i < 8; i++) begin
         hold_reset();
         release_reset();
         tick();
         pcSel = vecs[i].sel; exPc = vecs[i].ex_pc; exImm = vecs[i].ex_imm;
         jalrBase = vecs[i].base; imemAck = 1'b1; imemRdata = 32'h0;
         tick();
         set_idle();
         check($sformatf("vec%0d_addr", i), imemAddr, vecs[i].exp_addr);
         check($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].exp_flush));
         check($sformatf("vec%0d_trap", i), 32'(misalignTrap), 32'(vecs[i].exp_trap));
         check($sformatf("vec%0d_valid", i), 32'(ifValid), 32'(vecs[i].exp_valid));
         tick();
         check($sformatf("vec%0d_flush_end", i), 32'(flush), 32'h0);
         check($sformatf("vec%0d_trap_end", i), 32'(misalignTrap), 32'h0);
      end

      // Randomized run against the model.
      hold_reset();
      model_reset();
      release_reset();
      for (int c = 0; c < 600; c++) begin
         if (c != 0) begin
            check("rnd_req", 32'(imemReq), 32'(m_req()));
            if (m_req()) check("rnd_addr", imemAddr, m_drop ? m_drop_addr : m_pc);
            check("rnd_valid", 32'(ifValid), 32'(m_ifv));
            check("rnd_instr", ifInstr, m_ifi);
            check("rnd_ifpc", ifPc, m_ifp);
            check("rnd_flush", 32'(flush), 32'(m_flush));
            check("rnd_trap", 32'(misalignTrap), 32'(m_trap));
         end
         stall = ($urandom % 4) == 0;
         pcSel = (($urandom % 8) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         exPc = $urandom & 32'hFFFF_FFFC;
         exImm = (($urandom % 4) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
         jalrBase = $urandom;
         imemRdata = $urandom;
         imemAck = (m_req() || m_boot) ? (($urandom % 2) == 0) : 1'b0;
         model_step();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
